mem_port_arbiter: RTL and testbench

- Shares the single-port unified BRAM between the core's instruction-fetch requester and its load/store requester.
- One transaction is in flight at a time. The data port has priority, and a starvation counter guarantees that fetch makes progress.
- Sits between the core's fetch/load-store logic and the memory macro. It replaces the separate instr/data ports.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port BRAM between the fetch and load/store requesters.
// Optional MEM_PORT_ARBITER_BSWAP_EN: byte-reverses write data, read data and byte enables.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic       owner;       // 1 = data port owns the transaction
    logic       store;
    logic [3:0] starve_cnt;
    logic [3:0] wait_cnt;
    logic       d_win;

    function automatic logic [31:0] wdata_map(input logic [31:0] w);
`ifdef MEM_PORT_ARBITER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] rdata_map(input logic [31:0] r);
`ifdef MEM_PORT_ARBITER_BSWAP_EN
        return {r[7:0], r[15:8], r[23:16], r[31:24]};
`else
        return r;
`endif
    endfunction

    function automatic logic [3:0] we_map(input logic [3:0] we);
`ifdef MEM_PORT_ARBITER_BSWAP_EN
        return {we[0], we[1], we[2], we[3]};
`else
        return we;
`endif
    endfunction

    // Data wins unless fetch is waiting and has already lost STARVE_MAX times in a row.
    assign d_win = d_req && ((starve_cnt < STARVE_LIM) || !i_req);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            store      <= 1'b0;
            starve_cnt <= 4'd0;
            wait_cnt   <= 4'd0;
            i_gnt      <= 1'b0;
            i_rvalid   <= 1'b0;
            i_rdata    <= 32'd0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= 32'd0;
            mem_en     <= 1'b0;
            mem_we     <= 4'd0;
            mem_addr   <= 32'd0;
            mem_din    <= 32'd0;
            busy       <= 1'b0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 4'd0;
            case (state)
                S_IDLE: begin
                    if (!i_req)
                        starve_cnt <= 4'd0;
                    if (d_win) begin
                        owner    <= 1'b1;
                        store    <= |d_we;
                        d_gnt    <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_we   <= we_map(d_we);
                        mem_addr <= d_addr;
                        mem_din  <= wdata_map(d_wdata);
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                        if (i_req && (starve_cnt < STARVE_LIM))
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (i_req) begin
                        owner      <= 1'b0;
                        store      <= 1'b0;
                        i_gnt      <= 1'b1;
                        mem_en     <= 1'b1;
                        mem_addr   <= i_addr;
                        mem_din    <= 32'd0;
                        busy       <= 1'b1;
                        starve_cnt <= 4'd0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= LAT_INIT;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        if (owner) begin
                            d_rdata  <= store ? 32'd0 : rdata_map(mem_dout);
                            d_rvalid <= 1'b1;
                        end else begin
                            i_rdata  <= rdata_map(mem_dout);
                            i_rvalid <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level timeline model and a BRAM model.
module tb_mem_port_arbiter;

    localparam int LAT  = 1;
    localparam int SMAX = 4;
    localparam int NCYC = 3000;
    localparam int NEXP = NCYC + 32;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_we;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_din, mem_dout;
    logic [3:0]  mem_we;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] phys_din(input logic [31:0] w);
`ifdef MEM_PORT_ARBITER_BSWAP_EN
        return bswap(w);
`else
        return w;
`endif
    endfunction

    function automatic logic [3:0] phys_we(input logic [3:0] we);
`ifdef MEM_PORT_ARBITER_BSWAP_EN
        return {we[0], we[1], we[2], we[3]};
`else
        return we;
`endif
    endfunction

    // BRAM model holding the physical image; read-first, LAT-cycle output pipeline
    logic [31:0] phys [0:255];
    logic [31:0] dpipe [0:LAT-1];
    always @(posedge clk) begin
        if (mem_en) begin
            dpipe[0] <= phys[mem_addr[9:2]];
            for (int k = 0; k < 4; k++)
                if (mem_we[k]) phys[mem_addr[9:2]][8*k +: 8] <= mem_din[8*k +: 8];
        end
        for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign mem_dout = dpipe[LAT-1];

    // Reference model: requester-view memory and an expected-output timeline per cycle
    logic [31:0] ref_mem [0:255];
    bit          e_gi [0:NEXP], e_gd [0:NEXP], e_ri [0:NEXP], e_rd [0:NEXP];
    bit          e_en [0:NEXP], e_busy [0:NEXP];
    logic [3:0]  e_we [0:NEXP];
    logic [31:0] e_addr [0:NEXP], e_din [0:NEXP], e_iv [0:NEXP], e_dv [0:NEXP];
    logic [31:0] held_i, held_d;
    int          starve, next_idle;
    int          total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic issue_i(input logic [31:0] a);
        i_req  = 1'b1;
        i_addr = a;
    endtask

    task automatic issue_d(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        d_req   = 1'b1;
        d_addr  = a;
        d_we    = we;
        d_wdata = wd;
    endtask

    task automatic clear_future(input int from);
        for (int k = from; k <= NEXP; k++) begin
            e_gi[k] = 0; e_gd[k] = 0; e_ri[k] = 0; e_rd[k] = 0; e_en[k] = 0; e_busy[k] = 0;
            e_we[k] = '0; e_addr[k] = '0; e_din[k] = '0; e_iv[k] = '0; e_dv[k] = '0;
        end
    endtask

    // One transaction granted in idle cycle n: gnt at n+1, rvalid at n+2+LAT, idle again at n+3+LAT
    task automatic model_grant(input int n, input bit is_d);
        int g = n + 1;
        int r = n + 2 + LAT;
        logic [7:0] idx;
        for (int k = g; k <= r; k++) e_busy[k] = 1;
        e_en[g] = 1;
        if (is_d) begin
            idx = d_addr[9:2];
            e_gd[g] = 1; e_we[g] = phys_we(d_we); e_addr[g] = d_addr; e_din[g] = phys_din(d_wdata);
            e_rd[r] = 1;
            e_dv[r] = (d_we != 4'd0) ? 32'd0 : ref_mem[idx];
            for (int j = 0; j < 4; j++)
                if (d_we[j]) ref_mem[idx][8*j +: 8] = d_wdata[8*j +: 8];
        end else begin
            idx = i_addr[9:2];
            e_gi[g] = 1; e_we[g] = 4'd0; e_addr[g] = i_addr; e_din[g] = 32'd0;
            e_ri[r] = 1; e_iv[r] = ref_mem[idx];
        end
        next_idle = n + 3 + LAT;
    endtask

    task automatic rand_d();
        logic [3:0] we;
        we = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
        issue_d({22'd0, 8'($urandom_range(255)), 2'b00}, we, $urandom);
    endtask

    initial begin
        rstn = 1'b0; i_req = 1'b0; d_req = 1'b0;
        i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
        for (int w = 0; w < 256; w++) begin
            ref_mem[w] = 32'hC0DE0000 + 32'(w * 4);
            phys[w]    = phys_din(ref_mem[w]);
        end
        clear_future(0);
        held_i = '0; held_d = '0; starve = 0; next_idle = 3;

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            if (e_ri[n]) held_i = e_iv[n];
            if (e_rd[n]) held_d = e_dv[n];
            chk("i_gnt", 32'(i_gnt), 32'(e_gi[n]));
            chk("d_gnt", 32'(d_gnt), 32'(e_gd[n]));
            chk("i_rvalid", 32'(i_rvalid), 32'(e_ri[n]));
            chk("d_rvalid", 32'(d_rvalid), 32'(e_rd[n]));
            chk("busy", 32'(busy), 32'(e_busy[n]));
            chk("mem_en", 32'(mem_en), 32'(e_en[n]));
            chk("mem_we", 32'(mem_we), 32'(e_we[n]));
            chk("i_rdata", i_rdata, held_i);
            chk("d_rdata", d_rdata, held_d);
            if (e_en[n]) begin
                chk("mem_addr", mem_addr, e_addr[n]);
                chk("mem_din", mem_din, e_din[n]);
            end

            // Literal expectations for the directed opening
            if (n == 0) chk("pin_reset_busy", 32'(busy), 32'd0);
            if (n == 6) begin
                chk("pin_fetch_gnt", 32'(i_gnt), 32'd1);
                chk("pin_fetch_addr", mem_addr, 32'h100);
            end
            if (n >= 6 && n <= 9) chk("pin_fetch_busy", 32'(busy), (n <= 8) ? 32'd1 : 32'd0);
            if (n == 8) begin
                chk("pin_fetch_rvalid", 32'(i_rvalid), 32'd1);
                chk("pin_fetch_rdata", i_rdata, 32'hC0DE0100);
            end
            if (n == 13) begin
                chk("pin_prio_dgnt", 32'(d_gnt), 32'd1);
                chk("pin_prio_addr", mem_addr, 32'h30);
            end
            if (n == 17) chk("pin_prio_ignt", 32'(i_gnt), 32'd1);
            if (n == 35) chk("pin_starve_d4", 32'(d_gnt), 32'd1);
            if (n == 39) chk("pin_starve_ignt", 32'(i_gnt), 32'd1);
            if (n == 43) chk("pin_starve_dagain", 32'(d_gnt), 32'd1);
            if (n == 55) begin
                chk("pin_store_we", 32'(mem_we), 32'(phys_we(4'hF)));
                chk("pin_store_din", mem_din, phys_din(32'hDEADBEEF));
            end
            if (n == 56) chk("pin_store_we_off", 32'(mem_we), 32'd0);
            if (n == 57) begin
                chk("pin_store_rvalid", 32'(d_rvalid), 32'd1);
                chk("pin_store_rdata", d_rdata, 32'd0);
            end
            if (n == 71) chk("pin_reload_rdata", d_rdata, 32'hDEADBEEF);
            if (n == 75) begin
`ifdef MEM_PORT_ARBITER_BSWAP_EN
                chk("pin_bswap_din", mem_din, 32'h44332211);
                chk("pin_bswap_we", 32'(mem_we), 32'h8);
`else
                chk("pin_plain_din", mem_din, 32'h11223344);
                chk("pin_plain_we", 32'(mem_we), 32'h1);
`endif
            end
            if (n == 83) chk("pin_partial_rdata", d_rdata, 32'hC0DE0044);

            // Reset while a load sits in S_WAIT
            if (n == 64) begin
                chk("pin_wait_busy", 32'(busy), 32'd1);
                rstn = 1'b0;
                #1;
                chk("rst_outs_ctl", {26'd0, i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, busy}, 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
                chk("rst_i_rdata", i_rdata, 32'd0);
                chk("rst_d_rdata", d_rdata, 32'd0);
                chk("rst_mem_addr", mem_addr, 32'd0);
                chk("rst_mem_din", mem_din, 32'd0);
                clear_future(n + 1);
                held_i = '0; held_d = '0; starve = 0; next_idle = 66;
            end
            if (n == 66) rstn = 1'b1;
            if (n == 3) rstn = 1'b1;

            // Requesters: a granted request is consumed
            if (e_gi[n]) i_req = 1'b0;
            if (e_gd[n]) d_req = 1'b0;
            if (n < 90) begin
                if (n == 5)  issue_i(32'h100);
                if (n == 12) begin issue_i(32'h20); issue_d(32'h30, 4'd0, 32'd0); end
                if (n >= 22 && n < 50) begin
                    if (!i_req) issue_i({22'd0, 8'($urandom_range(255)), 2'b00});
                    if (!d_req) issue_d({22'd0, 8'($urandom_range(255)), 2'b00}, 4'd0, $urandom);
                end
                if (n == 50) begin i_req = 1'b0; d_req = 1'b0; end
                if (n == 54) issue_d(32'h40, 4'hF, 32'hDEADBEEF);
                if (n == 62) issue_d(32'h44, 4'd0, 32'd0);
                if (n == 68) issue_d(32'h40, 4'd0, 32'd0);
                if (n == 74) issue_d(32'h80, 4'b0001, 32'h11223344);
                if (n == 80) issue_d(32'h80, 4'd0, 32'd0);
            end else if (n < NCYC - 20) begin
                if (!i_req && $urandom_range(2) == 0) issue_i({22'd0, 8'($urandom_range(255)), 2'b00});
                else if (i_req && $urandom_range(39) == 0) i_req = 1'b0;
                if (!d_req && $urandom_range(2) == 0) rand_d();
                else if (d_req && $urandom_range(39) == 0) d_req = 1'b0;
            end else begin
                i_req = 1'b0; d_req = 1'b0;
            end

            // Arbitration decision for this idle cycle
            if (rstn && n >= next_idle) begin
                if (!i_req) starve = 0;
                if (d_req && (starve < SMAX || !i_req)) begin
                    if (i_req && starve < SMAX) starve++;
                    model_grant(n, 1'b1);
                end else if (i_req) begin
                    starve = 0;
                    model_grant(n, 1'b0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
